// File: rtl/dmem_bridge.sv
// Data-memory responder: serves 24-bit CPU word loads/stores as three
// little-endian byte transfers on a byte-wide synchronous SRAM, stalling the CPU meanwhile.
module dmem_bridge #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [23:0]       address,
  input  logic [23:0]       write_data,
  input  logic              mem_write,
  input  logic              mem_read,
  output logic [23:0]       read_data,
  output logic              stall,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_wdata,
  output logic              sram_we,
  output logic              sram_re,
  input  logic [7:0]        sram_rdata
);

  typedef enum logic [2:0] {IDLE, RD, RCAP, WR, DONE} state_t;

  state_t            state;
  logic [1:0]        cnt;
  logic [1:0]        cntNext;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] nextAddr;
  logic [23:0]       wordBuf;
  logic [23:0]       shadow;
  logic              unusedAddr;

  // CPU address bits above the SRAM width are deliberately dropped.
  assign unusedAddr = ^address;

  assign cntNext  = cnt + 2'd1;
  assign nextAddr = base + ADDR_W'(cntNext);

  assign stall = ((state == IDLE) && (mem_read || mem_write)) ||
                 (state == RD) || (state == RCAP) || (state == WR);

  function automatic logic [7:0] pickByte(input logic [23:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      default: return w[23:16];
    endcase
  endfunction

  // SRAM strobes/address are registered so they only ever change on the clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      base       <= '0;
      wordBuf    <= 24'd0;
      shadow     <= 24'd0;
      read_data  <= 24'd0;
      sram_addr  <= '0;
      sram_wdata <= 8'd0;
      sram_we    <= 1'b0;
      sram_re    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_write) begin
            base       <= address[ADDR_W-1:0];
            wordBuf    <= write_data;
            cnt        <= 2'd0;
            sram_we    <= 1'b1;
            sram_addr  <= address[ADDR_W-1:0];
            sram_wdata <= write_data[7:0];
            state      <= WR;
          end else if (mem_read) begin
            base      <= address[ADDR_W-1:0];
            cnt       <= 2'd0;
            sram_re   <= 1'b1;
            sram_addr <= address[ADDR_W-1:0];
            state     <= RD;
          end
        end
        RD: begin
          if (cnt == 2'd1)      shadow[7:0]  <= sram_rdata;
          else if (cnt == 2'd2) shadow[15:8] <= sram_rdata;
          if (cnt == 2'd2) begin
            sram_re   <= 1'b0;
            sram_addr <= '0;
            state     <= RCAP;
          end else begin
            cnt       <= cntNext;
            sram_addr <= nextAddr;
          end
        end
        RCAP: begin
          shadow[23:16] <= sram_rdata;
          read_data     <= {sram_rdata, shadow[15:0]};
          state         <= DONE;
        end
        WR: begin
          if (cnt == 2'd2) begin
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= 8'd0;
            state      <= DONE;
          end else begin
            cnt        <= cntNext;
            sram_addr  <= nextAddr;
            sram_wdata <= pickByte(wordBuf, cntNext);
          end
        end
        DONE: begin
          cnt   <= 2'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge with a behavioural byte SRAM.
`timescale 1ns/1ps
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] address = 24'd0;
  logic [23:0] write_data = 24'd0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [23:0] read_data;
  logic        stall;
  logic [15:0] sram_addr;
  logic [7:0]  sram_wdata;
  logic        sram_we;
  logic        sram_re;
  logic [7:0]  sram_rdata = 8'd0;

  logic [7:0]  mem [0:65535];
  logic        preWe = 1'b0;
  logic [15:0] preAddr = 16'd0;
  logic [7:0]  preData = 8'd0;
  int          weTotal = 0;
  int          reTotal = 0;
  int          total = 0;
  int          bad = 0;

  dmem_bridge #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .address(address), .write_data(write_data),
    .mem_write(mem_write), .mem_read(mem_read), .read_data(read_data),
    .stall(stall), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_we(sram_we), .sram_re(sram_re), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preWe) mem[preAddr] <= preData;
    else if (sram_we) mem[sram_addr] <= sram_wdata;
    if (sram_re) sram_rdata <= mem[sram_addr];
    if (sram_we) weTotal <= weTotal + 1;
    if (sram_re) reTotal <= reTotal + 1;
  end

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    preWe = 1'b1; preAddr = a; preData = d;
    @(posedge clk); #1;
    preWe = 1'b0;
  endtask

  // Requests are dropped and the address/data scrambled after the first edge.
  task automatic do_access(input logic wr, input logic rd, input logic [23:0] a,
                           input logic [23:0] wd, input int n, output logic [7:0] pat);
    pat = 8'd0;
    mem_write = wr; mem_read = rd; address = a; write_data = wd;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); pat[n-1-i] = stall;
      @(posedge clk); #1;
      mem_write = 1'b0; mem_read = 1'b0;
      address = 24'h000040; write_data = 24'hFFFFFF;
    end
  endtask

  task automatic test_reset();
    #3;
    total++; if (read_data !== 24'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=000000", read_data); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    total++; if (sram_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", sram_we); end
    total++; if (sram_re !== 1'b0) begin bad++; $display("FAIL reset_re got=%b exp=0", sram_re); end
    total++; if (sram_addr !== 16'd0) begin bad++; $display("FAIL reset_addr got=%h exp=0000", sram_addr); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    logic [7:0] pat;
    do_access(1'b1, 1'b0, 24'h000030, 24'hA1B2C3, 5, pat);
    total++; if (pat !== 8'h1E) begin bad++; $display("FAIL store_stall got=%h exp=1e", pat); end
    total++; if (mem[16'h30] !== 8'hC3) begin bad++; $display("FAIL store_b0 got=%h exp=c3", mem[16'h30]); end
    total++; if (mem[16'h31] !== 8'hB2) begin bad++; $display("FAIL store_b1 got=%h exp=b2", mem[16'h31]); end
    total++; if (mem[16'h32] !== 8'hA1) begin bad++; $display("FAIL store_b2 got=%h exp=a1", mem[16'h32]); end
    do_access(1'b0, 1'b1, 24'h000030, 24'd0, 6, pat);
    total++; if (pat !== 8'h3E) begin bad++; $display("FAIL load_stall got=%h exp=3e", pat); end
    total++; if (read_data !== 24'hA1B2C3) begin bad++; $display("FAIL load_data got=%h exp=a1b2c3", read_data); end
  endtask

  task automatic test_wrap();
    logic [7:0] pat;
    do_access(1'b1, 1'b0, 24'h00FFFF, 24'h123456, 5, pat);
    total++; if (mem[16'hFFFF] !== 8'h56) begin bad++; $display("FAIL wrap_b0 got=%h exp=56", mem[16'hFFFF]); end
    total++; if (mem[16'h0000] !== 8'h34) begin bad++; $display("FAIL wrap_b1 got=%h exp=34", mem[16'h0000]); end
    total++; if (mem[16'h0001] !== 8'h12) begin bad++; $display("FAIL wrap_b2 got=%h exp=12", mem[16'h0001]); end
    do_access(1'b0, 1'b1, 24'h00FFFF, 24'd0, 6, pat);
    total++; if (read_data !== 24'h123456) begin bad++; $display("FAIL wrap_load got=%h exp=123456", read_data); end
  endtask

  task automatic test_simultaneous();
    logic [7:0]  pat;
    logic [23:0] prev;
    int we0, re0;
    prev = read_data; we0 = weTotal; re0 = reTotal;
    do_access(1'b1, 1'b1, 24'h000010, 24'h0F0F0F, 5, pat);
    total++; if (pat !== 8'h1E) begin bad++; $display("FAIL both_stall got=%h exp=1e", pat); end
    total++; if (weTotal - we0 !== 3) begin bad++; $display("FAIL both_we got=%0d exp=3", weTotal - we0); end
    total++; if (reTotal - re0 !== 0) begin bad++; $display("FAIL both_re got=%0d exp=0", reTotal - re0); end
    total++; if (read_data !== prev) begin bad++; $display("FAIL both_rdata got=%h exp=%h", read_data, prev); end
    total++; if (mem[16'h12] !== 8'h0F) begin bad++; $display("FAIL both_b2 got=%h exp=0f", mem[16'h12]); end
  endtask

  task automatic test_churn();
    logic [7:0] pat;
    preload(16'h20, 8'h11); preload(16'h21, 8'h22); preload(16'h22, 8'h33);
    preload(16'h40, 8'hAA); preload(16'h41, 8'hBB); preload(16'h42, 8'hCC);
    do_access(1'b0, 1'b1, 24'h000020, 24'd0, 6, pat);
    total++; if (pat !== 8'h3E) begin bad++; $display("FAIL churn_stall got=%h exp=3e", pat); end
    total++; if (read_data !== 24'h332211) begin bad++; $display("FAIL churn_data got=%h exp=332211", read_data); end
  endtask

  task automatic test_reset_mid_write();
    int we0;
    preload(16'h50, 8'hEE); preload(16'h51, 8'hEE); preload(16'h52, 8'hEE);
    mem_write = 1'b1; address = 24'h000050; write_data = 24'h445566;
    @(posedge clk); #1; mem_write = 1'b0;
    @(posedge clk); #1;
    total++; if (sram_we !== 1'b1) begin bad++; $display("FAIL rmw_we_before got=%b exp=1", sram_we); end
    #2 rst = 1'b1;
    #1;
    total++; if (sram_we !== 1'b0) begin bad++; $display("FAIL rmw_we got=%b exp=0", sram_we); end
    total++; if (sram_addr !== 16'd0) begin bad++; $display("FAIL rmw_addr got=%h exp=0000", sram_addr); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rmw_stall got=%b exp=0", stall); end
    total++; if (read_data !== 24'd0) begin bad++; $display("FAIL rmw_rdata got=%h exp=000000", read_data); end
    @(negedge clk); rst = 1'b0;
    we0 = weTotal;
    repeat (3) begin @(posedge clk); #1; end
    total++; if (weTotal - we0 !== 0) begin bad++; $display("FAIL rmw_no_resume got=%0d exp=0", weTotal - we0); end
    total++; if (mem[16'h50] !== 8'h66) begin bad++; $display("FAIL rmw_b0 got=%h exp=66", mem[16'h50]); end
    total++; if (mem[16'h51] !== 8'hEE) begin bad++; $display("FAIL rmw_b1 got=%h exp=ee", mem[16'h51]); end
    total++; if (mem[16'h52] !== 8'hEE) begin bad++; $display("FAIL rmw_b2 got=%h exp=ee", mem[16'h52]); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] pat;
    int re0;
    for (int k = 0; k < 6; k++) preload(16'(k), 8'(k + 1));
    re0 = reTotal; pat = 12'd0;
    mem_read = 1'b1; address = 24'h000000;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); pat[11-i] = stall;
      if (i == 5) begin
        total++; if (read_data !== 24'h030201) begin bad++; $display("FAIL b2b_first got=%h exp=030201", read_data); end
      end
      @(posedge clk); #1;
      if (i == 0) address = 24'h000003;
      if (i == 6) mem_read = 1'b0;
    end
    total++; if (pat !== 12'b111110_111110) begin bad++; $display("FAIL b2b_stall got=%b exp=111110111110", pat); end
    total++; if (read_data !== 24'h060504) begin bad++; $display("FAIL b2b_second got=%h exp=060504", read_data); end
    repeat (3) begin @(posedge clk); #1; end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_idle_stall got=%b exp=0", stall); end
    total++; if (reTotal - re0 !== 6) begin bad++; $display("FAIL b2b_re_count got=%0d exp=6", reTotal - re0); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_wrap();
    test_simultaneous();
    test_churn();
    test_reset_mid_write();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
